// File: rtl/seqdet.sv
// seqdet: serial bit-sequence detector that pulses z for one cycle per pattern match
// Ports: clk (rising-edge clock), tst_n (async active-low reset),
//        x (serial data, one bit per edge), z (registered match flag)
// Build option: define SEQDET_OVERLAP_EN for overlapping detection; by default
//        the history restarts after every match (non-overlapping detection).
module seqdet #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010
) (
  input  logic clk,
  input  logic tst_n,
  input  logic x,
  output logic z
);
  localparam int CW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_n;
  logic               z_q, z_d, match;
  always_comb begin
    hist_n = {hist_q[PAT_LEN-2:0], x};
    cnt_n  = (cnt_q == CW'(PAT_LEN)) ? cnt_q : cnt_q + CW'(1);
    // cnt guards against matching on reset-zero history bits
    match  = (cnt_n == CW'(PAT_LEN)) && (hist_n == PATTERN);
    z_d    = match;
`ifdef SEQDET_OVERLAP_EN
    hist_d = hist_n;
    cnt_d  = cnt_n;
`else
    hist_d = match ? '0 : hist_n;
    cnt_d  = match ? '0 : cnt_n;
`endif
  end
  always_ff @(posedge clk or negedge tst_n)
    if (!tst_n) begin
      hist_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  assign z = z_q;
endmodule

// File: tb/tb_seqdet.sv
// tb_seqdet: directed and random checks of seqdet against a queue-based reference model
module tb_seqdet;
  logic clk = 1'b0;
  logic tst_n = 1'b0;
  logic x = 1'b0;
  logic z, z3;
  int checks = 0;
  int errors = 0;
  bit q5[$];
  bit q3[$];
  bit e5, e3;
  logic [31:0] z3_hist;
`ifdef SEQDET_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif
  always #5 clk = ~clk;
  seqdet dut (.clk(clk), .tst_n(tst_n), .x(x), .z(z));
  seqdet #(.PAT_LEN(3), .PATTERN(3'b111)) dut3 (.clk(clk), .tst_n(tst_n), .x(x), .z(z3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // true when the newest l bits received since the last restart spell p (first bit = p[l-1])
  function automatic bit tail_is(input bit q[$], input int l, input logic [31:0] p);
    if (q.size() < l) return 1'b0;
    for (int i = 0; i < l; i++)
      if (q[q.size() - l + i] != p[l-1-i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic step(input bit b, input string tag);
    @(negedge clk);
    x = b;
    @(posedge clk);
    #1;
    if (tst_n) begin
      q5.push_back(b);
      e5 = tail_is(q5, 5, 32'b10010);
      if (e5 && !OV) q5.delete();
      if (q5.size() > 5) void'(q5.pop_front());
      q3.push_back(b);
      e3 = tail_is(q3, 3, 32'b111);
      if (e3 && !OV) q3.delete();
      if (q3.size() > 3) void'(q3.pop_front());
    end else begin
      e5 = 1'b0;
      e3 = 1'b0;
    end
    z3_hist = {z3_hist[30:0], z3};
    chk({tag, "/z"}, 32'(z), 32'(e5));
    chk({tag, "/z3"}, 32'(z3), 32'(e3));
  endtask
  task automatic seq(input logic [31:0] bits, input int n, input logic [31:0] zexp, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], $sformatf("%s[%0d]", tag, n - i));
      chk($sformatf("%s[%0d]/const", tag, n - i), 32'(z), 32'(zexp[i]));
    end
  endtask
  task automatic do_reset(input int edges, input logic [31:0] bits);
    tst_n = 1'b0;
    #1;
    chk("rst/z", 32'(z), 32'd0);
    chk("rst/z3", 32'(z3), 32'd0);
    q5.delete();
    q3.delete();
    for (int i = edges - 1; i >= 0; i--) step(bits[i], $sformatf("rst_hold[%0d]", edges - i));
    #1;
    tst_n = 1'b1;
  endtask
  initial begin
    z3_hist = '0;
    do_reset(5, 32'b10010);
    seq(32'b1, 1, 32'b0, "post_rst");
    do_reset(0, 32'b0);
    seq(32'b10010, 5, 32'b00001, "single");
    #2;
    tst_n = 1'b0;
    #1;
    chk("async_clear/z", 32'(z), 32'd0);
    #1;
    tst_n = 1'b1;
    do_reset(0, 32'b0);
    seq(32'b10010010, 8, OV ? 32'b00001001 : 32'b00001000, "overlap");
    do_reset(0, 32'b0);
    seq(32'b1001010010, 10, 32'b0000100001, "restart");
    do_reset(0, 32'b0);
    seq(32'b1001100011, 10, 32'b0, "near_miss");
    do_reset(0, 32'b0);
    seq(32'b1001, 4, 32'b0, "mid_a");
    do_reset(0, 32'b0);
    seq(32'b0, 1, 32'b0, "mid_b");
    seq(32'b10010, 5, 32'b00001, "mid_c");
    do_reset(0, 32'b0);
    z3_hist = '0;
    seq(32'b11111, 5, 32'b0, "ones");
    chk("ones/z3_run", {27'd0, z3_hist[4:0]}, OV ? 32'b00111 : 32'b00100);
    do_reset(0, 32'b0);
    for (int i = 0; i < 300; i++) step(1'($urandom % 2), $sformatf("rand[%0d]", i));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seqdet.md
# seqdet

Serial bit-sequence detector. It samples one input bit `x` per rising edge of `clk` and pulses `z` for one clock cycle each time the most recent bits, in arrival order, equal a programmable pattern (default `10010`). It is a leaf block in the serial front end and drives a single-bit, registered event flag to downstream logic.

## Interface
Parameters:
- `PAT_LEN`, default 5: pattern length in bits. Legal range is 2..32.
- `PATTERN`, default `5'b10010`: the target sequence. `PATTERN[PAT_LEN-1]` is the first bit received and `PATTERN[0]` is the last.

Ports:
- `clk`, input, 1 bit: the only clock. All state updates on the rising edge.
- `tst_n`, input, 1 bit: reset. Asynchronous, active-low.
- `x`, input, 1 bit: serial data. Sampled on every rising `clk` edge while `tst_n` = 1.
- `z`, output, 1 bit: match flag. Registered; high for one cycle per detected match.

## Operation
- Internal state:
  - `hist[PAT_LEN-1:0]`: history shift register. The newest bit enters at bit 0.
  - `cnt`: count of valid history bits, 0..`PAT_LEN`, saturating.
- Each edge: `hist_next = {hist[PAT_LEN-2:0], x}` and `cnt_next = min(cnt+1, PAT_LEN)`.
- A match is declared when both of these hold: `cnt_next == PAT_LEN` and `hist_next == PATTERN`.
- `z_next` = 1 on a match, otherwise 0.
- After a match, the history is handled according to `SEQDET_OVERLAP_EN` (see Configuration).
- `x` has no valid or enable qualifier. Every edge consumes exactly one bit.
- An X or Z value on `x` is out of contract. The design does no checking.

## Timing
- Reset (`tst_n` = 0): `z` = 0, `hist` = 0 and `cnt` = 0 immediately, with no clock needed. All state is held while reset is low.
- Reset release: the first rising edge with `tst_n` = 1 samples bit #1. A match is therefore impossible earlier than the `PAT_LEN`-th edge after release.
- Latency: `z` rises at the same edge that samples the final pattern bit. It is valid for the following full cycle and drops at the next edge unless that edge also completes a match.
- Reset asserted mid-sequence: all partial progress is discarded and `z` clears asynchronously. There is no carry-over after release.
- Back-to-back matches are only possible with overlap enabled and a self-overlapping pattern (for example all-ones). In that case `z` stays high on consecutive cycles.
- The bench drives `x` on the falling edge, so setup and hold at the rising edge are trivially met.

## Configuration
The macro is `SEQDET_OVERLAP_EN`.
- Defined (overlapping detection): after a match, `hist` and `cnt` update normally. The suffix of a matched sequence can begin the next match. With the default pattern, `10010010` gives `z` pulses at bits 5 and 8.
- Undefined (non-overlapping detection): on a match edge, `cnt` is forced to 0 and `hist` to 0. Matching restarts from the next bit. With the default pattern, `10010010` gives one pulse, at bit 5, and `1001010010` gives pulses at bits 5 and 10.

## Test plan
1. Reset check: hold `tst_n` = 0 across 5 edges while `x` carries `10010` → `z` = 0 throughout, and `z` = 0 at the first edge after release.
2. Single match: after reset, drive `1,0,0,1,0` → `z` = 1 only in the cycle after the 5th edge, and 0 at all other times.
3. Overlap:
   - Drive `10010010` with `SEQDET_OVERLAP_EN` defined → `z` pulses after bits 5 and 8.
   - Drive the same stream with the macro undefined → `z` pulses after bit 5 only.
4. Near misses: drive `1001100011` → `z` never asserts.
5. Mid-sequence reset: drive `1001`, pulse `tst_n` low asynchronously between edges, then drive `0` → no pulse. Then drive `10010` → pulse after its 5th bit.
6. Random soak: drive 300 cycles of random `x` and compare against a software reference model for the same `PATTERN` and overlap mode → zero mismatches. The self-overlapping case is also run with `PATTERN` = `3'b111` and 5 ones → `z` high for 3 consecutive cycles in overlap mode, and high once in non-overlap mode.
